// File: rtl/mac_tx_mon_pkg.sv
// Shared types and constants for the MAC TX gate monitor: FSM states,
// err_flags bit positions and the framing bytes.
package mac_tx_mon_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE      = 3'd1,
        DATA     = 3'd2,
        WAIT_LOW = 3'd3,
        IFG      = 3'd4
    } mon_state_e;

    localparam int ERR_PRE   = 0;
    localparam int ERR_RUNT  = 1;
    localparam int ERR_GIANT = 2;
    localparam int ERR_GATE  = 3;
    localparam int ERR_IFG   = 4;
    localparam int ERR_W     = 5;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    function automatic logic [ERR_W-1:0] pack_flags(
        input logic ifg,
        input logic gate,
        input logic giant,
        input logic runt,
        input logic pre
    );
        logic [ERR_W-1:0] f;
        f            = '0;
        f[ERR_IFG]   = ifg;
        f[ERR_GATE]  = gate;
        f[ERR_GIANT] = giant;
        f[ERR_RUNT]  = runt;
        f[ERR_PRE]   = pre;
        return f;
    endfunction

endpackage

// File: rtl/mac_tx_sat_cnt.sv
// Saturating statistics counter; clr wins over a same-cycle inc.
module mac_tx_sat_cnt
    import mac_tx_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mac_tx_gate_monitor.sv
// Byte-wide MAC TX monitor: framing, length, IFG and gate compliance checks
// with saturating statistics. Per-TC counters: MAC_TX_GATE_MONITOR_PER_TC_CNT_EN.
module mac_tx_gate_monitor
    import mac_tx_mon_pkg::*;
#(
    parameter int NUM_GATES    = 8,
    parameter int CNT_W        = 32,
    parameter int LEN_W        = 16,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 64,
    parameter int MAX_FRAME    = 1522,
    parameter int IFG_MIN      = 12,
    parameter int TC_W         = $clog2(NUM_GATES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mac_tx_en,
    input  logic [7:0]                 mac_tx_d,
    input  logic [NUM_GATES-1:0]       gate_state,
    input  logic [TC_W-1:0]            frame_tc,
    input  logic                       clr_cnt,
    output logic                       frame_done,
    output logic [LEN_W-1:0]           frame_len,
    output logic [TC_W-1:0]            frame_tc_o,
    output logic [ERR_W-1:0]           err_flags,
    output logic [CNT_W-1:0]           good_frame_cnt,
    output logic [CNT_W-1:0]           err_frame_cnt,
    output logic [CNT_W-1:0]           gate_viol_cnt,
    output logic [NUM_GATES*CNT_W-1:0] tc_frame_cnt
);

    localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam int IFG_W = $clog2(IFG_MIN + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN);
    localparam logic [IFG_W-1:0] IFG_DONE = IFG_W'(IFG_MIN);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_FRAME);

    mon_state_e       state;
    logic [PRE_W-1:0] pre_cnt;
    logic [LEN_W-1:0] len;
    logic [TC_W-1:0]  tc_q;
    logic             in_frame;
    logic             pre_err;
    logic             gate_err;
    logic             ifg_err;
    logic [IFG_W-1:0] ifg_cnt;

    logic             ifg_short;
    logic [IFG_W-1:0] ifg_cnt_inc;

    // The idle counter parks at IFG_MIN; reset starts it there so the first
    // frame after reset never sees an IFG error.
    assign ifg_short   = (state == IFG) && (ifg_cnt < IFG_DONE);
    assign ifg_cnt_inc = (ifg_cnt >= IFG_DONE) ? IFG_DONE : ifg_cnt + 1'b1;

    // frame_done is a one-cycle valid strobe with no ready: frame_len,
    // frame_tc_o and err_flags are valid while it is high and held after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= WAIT_LOW;
            pre_cnt    <= '0;
            len        <= '0;
            tc_q       <= '0;
            in_frame   <= 1'b0;
            pre_err    <= 1'b0;
            gate_err   <= 1'b0;
            ifg_err    <= 1'b0;
            ifg_cnt    <= IFG_DONE;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_tc_o <= '0;
            err_flags  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE, IFG: begin
                    if (mac_tx_en) begin
                        tc_q     <= frame_tc;
                        in_frame <= 1'b1;
                        len      <= '0;
                        ifg_err  <= ifg_short;
                        gate_err <= !gate_state[frame_tc];
                        if (mac_tx_d == PREAMBLE_BYTE) begin
                            state   <= PRE;
                            pre_cnt <= PRE_W'(1);
                            pre_err <= 1'b0;
                        end else begin
                            state   <= WAIT_LOW;
                            pre_err <= 1'b1;
                        end
                    end else if (state == IFG) begin
                        ifg_cnt <= ifg_cnt_inc;
                        if (ifg_cnt_inc == IFG_DONE) begin
                            state <= IDLE;
                        end
                    end
                end

                PRE: begin
                    if (!mac_tx_en) begin
                        frame_done <= 1'b1;
                        frame_len  <= len;
                        frame_tc_o <= tc_q;
                        err_flags  <= pack_flags(ifg_err, gate_err, 1'b0, 1'b0, 1'b1);
                        in_frame   <= 1'b0;
                        ifg_cnt    <= IFG_W'(1);
                        state      <= IFG;
                    end else begin
                        if (!gate_state[tc_q]) begin
                            gate_err <= 1'b1;
                        end
                        if ((mac_tx_d == PREAMBLE_BYTE) && (pre_cnt < PRE_LAST)) begin
                            pre_cnt <= pre_cnt + 1'b1;
                        end else if ((mac_tx_d == SFD_BYTE) && (pre_cnt == PRE_LAST)) begin
                            state <= DATA;
                            len   <= '0;
                        end else begin
                            pre_err <= 1'b1;
                            state   <= WAIT_LOW;
                        end
                    end
                end

                DATA: begin
                    if (mac_tx_en) begin
                        if (!gate_state[tc_q]) begin
                            gate_err <= 1'b1;
                        end
                        if (len != '1) begin
                            len <= len + 1'b1;
                        end
                    end else begin
                        frame_done <= 1'b1;
                        frame_len  <= len;
                        frame_tc_o <= tc_q;
                        err_flags  <= pack_flags(ifg_err, gate_err, len > LEN_MAX,
                                                 len < LEN_MIN, pre_err);
                        in_frame   <= 1'b0;
                        ifg_cnt    <= IFG_W'(1);
                        state      <= IFG;
                    end
                end

                WAIT_LOW: begin
                    if (mac_tx_en) begin
                        if (in_frame && !gate_state[tc_q]) begin
                            gate_err <= 1'b1;
                        end
                    end else begin
                        // Without an open frame (post-reset) the IFG credit is kept.
                        if (in_frame) begin
                            frame_done <= 1'b1;
                            frame_len  <= len;
                            frame_tc_o <= tc_q;
                            err_flags  <= pack_flags(ifg_err, gate_err, 1'b0, 1'b0, pre_err);
                            ifg_cnt    <= IFG_W'(1);
                        end
                        in_frame <= 1'b0;
                        state    <= IFG;
                    end
                end

                default: state <= WAIT_LOW;
            endcase
        end
    end

    logic fd_good;
    logic fd_err;
    logic fd_gate;

    assign fd_good = frame_done && (err_flags == '0);
    assign fd_err  = frame_done && (|err_flags);
    assign fd_gate = frame_done && err_flags[ERR_GATE];

    mac_tx_sat_cnt #(.CNT_W(CNT_W)) u_good_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fd_good),
        .clr   (clr_cnt),
        .cnt   (good_frame_cnt)
    );

    mac_tx_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fd_err),
        .clr   (clr_cnt),
        .cnt   (err_frame_cnt)
    );

    mac_tx_sat_cnt #(.CNT_W(CNT_W)) u_gate_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fd_gate),
        .clr   (clr_cnt),
        .cnt   (gate_viol_cnt)
    );

`ifdef MAC_TX_GATE_MONITOR_PER_TC_CNT_EN
    for (genvar g = 0; g < NUM_GATES; g++) begin : g_tc_cnt
        logic tc_inc;
        assign tc_inc = fd_good && (frame_tc_o == TC_W'(g));

        mac_tx_sat_cnt #(.CNT_W(CNT_W)) u_tc_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (tc_inc),
            .clr   (clr_cnt),
            .cnt   (tc_frame_cnt[g*CNT_W +: CNT_W])
        );
    end
`else
    assign tc_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_tx_gate_monitor.sv
// Directed bench for mac_tx_gate_monitor: framing, length, gate, IFG,
// counter saturation/clear and mid-frame reset.
module tb_mac_tx_gate_monitor;

    localparam int NG = 8;
    localparam int CW = 4;
    localparam int LW = 16;
    localparam int TW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mac_tx_en = 1'b0;
    logic [7:0]     mac_tx_d = 8'h00;
    logic [NG-1:0]  gate_state = '1;
    logic [TW-1:0]  frame_tc = '0;
    logic           clr_cnt = 1'b0;
    logic           frame_done;
    logic [LW-1:0]  frame_len;
    logic [TW-1:0]  frame_tc_o;
    logic [4:0]     err_flags;
    logic [CW-1:0]  good_frame_cnt;
    logic [CW-1:0]  err_frame_cnt;
    logic [CW-1:0]  gate_viol_cnt;
    logic [NG*CW-1:0] tc_frame_cnt;

    mac_tx_gate_monitor #(
        .NUM_GATES (NG),
        .CNT_W     (CW),
        .LEN_W     (LW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mac_tx_en      (mac_tx_en),
        .mac_tx_d       (mac_tx_d),
        .gate_state     (gate_state),
        .frame_tc       (frame_tc),
        .clr_cnt        (clr_cnt),
        .frame_done     (frame_done),
        .frame_len      (frame_len),
        .frame_tc_o     (frame_tc_o),
        .err_flags      (err_flags),
        .good_frame_cnt (good_frame_cnt),
        .err_frame_cnt  (err_frame_cnt),
        .gate_viol_cnt  (gate_viol_cnt),
        .tc_frame_cnt   (tc_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int n_exp    = 0;

    // Expected frame record: {check_len, len[15:0], tc[2:0], flags[4:0]}
    logic [24:0] exp_q[$];
    logic [24:0] mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] d, input logic [NG-1:0] g);
        mac_tx_en  = en;
        mac_tx_d   = d;
        gate_state = g;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, '1);
    endtask

    task automatic push_exp(input logic chk_len, input logic [15:0] len,
                            input logic [2:0] tc, input logic [4:0] flags);
        exp_q.push_back({chk_len, len, tc, flags});
        n_exp++;
    endtask

    task automatic send_frame(input int npre, input int ndata, input logic [2:0] tc,
                              input int drop_idx);
        logic [NG-1:0] g;
        frame_tc = tc;
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, '1);
        drive(1'b1, 8'hD5, '1);
        for (int i = 0; i < ndata; i++) begin
            g = '1;
            if (i == drop_idx) g[tc] = 1'b0;
            drive(1'b1, 8'($urandom_range(0, 255)), g);
        end
    endtask

    task automatic finish_frame(input logic clr_at_done);
        check("no_early_done", done_cnt, n_exp - 1);
        drive(1'b0, 8'h00, '1);
        check("done_pulse", frame_done, 1'b1);
        clr_cnt = clr_at_done;
        drive(1'b0, 8'h00, '1);
        clr_cnt = 1'b0;
        check("done_one_cycle", frame_done, 1'b0);
        check("done_count", done_cnt, n_exp);
    endtask

    task automatic check_cnts(input logic [CW-1:0] good, input logic [CW-1:0] err,
                              input logic [CW-1:0] gate);
        check("good_cnt", good_frame_cnt, good);
        check("err_cnt", err_frame_cnt, err);
        check("gate_cnt", gate_viol_cnt, gate);
    endtask

    task automatic check_tc(input int idx, input logic [CW-1:0] exp);
`ifdef MAC_TX_GATE_MONITOR_PER_TC_CNT_EN
        check("tc_cnt", tc_frame_cnt[idx*CW +: CW], exp);
`else
        check("tc_cnt_tied", tc_frame_cnt, {idx[0] & 1'b0, exp & 4'h0});
`endif
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        drive(1'b0, 8'h00, '1);
        clr_cnt = 1'b0;
    endtask

    // Scoreboard: every frame_done pops one expected record.
    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e[24]) check("frame_len", frame_len, mon_e[23:8]);
                check("frame_tc_o", frame_tc_o, mon_e[7:5]);
                check("err_flags", err_flags, mon_e[4:0]);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        idle(3);
        check("rst_done", frame_done, 1'b0);
        check("rst_len", frame_len, 16'h0);
        check("rst_tc", frame_tc_o, 3'h0);
        check("rst_flags", err_flags, 5'h0);
        check_cnts(0, 0, 0);
        check("rst_tc_cnt", tc_frame_cnt, 32'h0);
        rst_n = 1'b1;
        idle(3);

        // Clean minimum-length frame on TC3
        push_exp(1'b1, 16'd64, 3'd3, 5'b00000);
        send_frame(7, 64, 3'd3, -1);
        finish_frame(1'b0);
        check_cnts(1, 0, 0);
        check_tc(3, 1);
        idle(10);

        // Gate for TC3 closed for one data byte
        push_exp(1'b1, 16'd64, 3'd3, 5'b01000);
        send_frame(7, 64, 3'd3, 20);
        finish_frame(1'b0);
        check_cnts(1, 1, 1);
        idle(10);

        pulse_clr();
        check_cnts(0, 0, 0);
        check_tc(3, 0);

        // Runt, giant, then maximum legal length
        push_exp(1'b1, 16'd63, 3'd1, 5'b00010);
        send_frame(7, 63, 3'd1, -1);
        finish_frame(1'b0);
        check_cnts(0, 1, 0);
        idle(10);
        push_exp(1'b1, 16'd1523, 3'd2, 5'b00100);
        send_frame(7, 1523, 3'd2, -1);
        finish_frame(1'b0);
        check_cnts(0, 2, 0);
        idle(10);
        push_exp(1'b1, 16'd1522, 3'd2, 5'b00000);
        send_frame(7, 1522, 3'd2, -1);
        finish_frame(1'b0);
        check_cnts(1, 2, 0);
        check_tc(2, 1);
        idle(10);

        // Short preamble: SFD after six 0x55, trailing bytes ignored
        push_exp(1'b0, 16'd0, 3'd4, 5'b00001);
        send_frame(6, 5, 3'd4, -1);
        finish_frame(1'b0);
        check_cnts(1, 3, 0);
        idle(10);

        // IFG of 11 idle cycles (error), then 12 (clean)
        push_exp(1'b1, 16'd64, 3'd5, 5'b00000);
        send_frame(7, 64, 3'd5, -1);
        finish_frame(1'b0);
        idle(9);
        push_exp(1'b1, 16'd64, 3'd0, 5'b10000);
        send_frame(7, 64, 3'd0, -1);
        finish_frame(1'b0);
        idle(10);
        push_exp(1'b1, 16'd64, 3'd7, 5'b00000);
        send_frame(7, 64, 3'd7, -1);
        finish_frame(1'b0);
        check_cnts(3, 4, 0);
        check_tc(5, 1);
        check_tc(0, 0);
        check_tc(7, 1);
        idle(10);

        // Drive err_frame_cnt to saturation with one-byte preamble errors
        pulse_clr();
        check_cnts(0, 0, 0);
        frame_tc = 3'd6;
        for (int i = 0; i < 16; i++) begin
            push_exp(1'b0, 16'd0, 3'd6, 5'b00001);
            drive(1'b1, 8'h00, '1);
            finish_frame(1'b0);
            idle(10);
            if (i == 14) check("err_cnt_at_max", err_frame_cnt, 4'hF);
        end
        check("err_cnt_saturated", err_frame_cnt, 4'hF);
        push_exp(1'b0, 16'd0, 3'd6, 5'b00001);
        drive(1'b1, 8'h00, '1);
        finish_frame(1'b1);
        check("err_cnt_clr_wins", err_frame_cnt, 4'h0);
        idle(1);
        check("err_cnt_inc_lost", err_frame_cnt, 4'h0);
        idle(10);

        // Reset in the middle of a frame, released while tx_en is still high
        push_exp(1'b1, 16'd64, 3'd6, 5'b00000);
        send_frame(7, 64, 3'd6, -1);
        finish_frame(1'b0);
        check_cnts(1, 0, 0);
        check_tc(6, 1);
        idle(10);
        send_frame(7, 20, 3'd2, -1);
        rst_n = 1'b0;
        drive(1'b1, 8'h11, '1);
        drive(1'b1, 8'h22, '1);
        check("mid_rst_done", frame_done, 1'b0);
        check("mid_rst_len", frame_len, 16'h0);
        check("mid_rst_flags", err_flags, 5'h0);
        check("mid_rst_tc", frame_tc_o, 3'h0);
        check_cnts(0, 0, 0);
        check("mid_rst_tc_cnt", tc_frame_cnt, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h55, '1);
        idle(4);
        check("no_done_after_rst", done_cnt, n_exp);
        check_cnts(0, 0, 0);
        idle(10);

        push_exp(1'b1, 16'd100, 3'd1, 5'b00000);
        send_frame(7, 100, 3'd1, -1);
        finish_frame(1'b0);
        check_cnts(1, 0, 0);
        check_tc(1, 1);
        idle(4);

        check("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
